// File: rtl/dac_lane_framer.sv
// Multi-channel DAC lane framer: buffers parallel sample beats and drives serializer
// data, frame and sync lanes through an IDLE -> SYNC -> PRIME -> RUN sequence.
module dac_lane_framer #(
  parameter int NUM_CH      = 2,
  parameter int DATA_WIDTH  = 16,
  parameter int RATIO       = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int PRIME_LEVEL = 4,
  parameter int SYNC_LEN    = 16,
  parameter logic [RATIO-1:0] FRAME_PAT = RATIO'(4'b0011),
  parameter logic [RATIO-1:0] SYNC_PAT  = RATIO'(4'b0011)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 enable,
  input  logic                                 sync_req,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic [NUM_CH*RATIO*DATA_WIDTH-1:0]   s_data,
  output logic [NUM_CH*RATIO*DATA_WIDTH-1:0]   ser_data,
  output logic [RATIO-1:0]                     frame_word,
  output logic [RATIO-1:0]                     sync_word,
  input  logic                                 underflow_clr,
  output logic                                 underflow,
  output logic [15:0]                          underflow_cnt,
  output logic [$clog2(FIFO_DEPTH):0]          fifo_level,
  output logic [1:0]                           state
);

  localparam int BW = NUM_CH * RATIO * DATA_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L   = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] PRIME_L   = (AW+1)'(PRIME_LEVEL);
  localparam logic [7:0]  SYNC_LAST = 8'(SYNC_LEN - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, PRIME = 2'd2, RUN = 2'd3} state_t;

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [BW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     level_q;
  logic            push, pop, uf_event, flush;
  logic [BW-1:0]   ser_d;
  logic [RATIO-1:0] frame_d, sync_d;

  // Handshake: a beat transfers on a rising clk edge where s_valid && s_ready.
  // s_ready is also held low in IDLE because the FIFO is flushed there.
  assign s_ready    = enable && !rst && (state_q != IDLE) && (level_q < DEPTH_L);
  assign push       = s_valid && s_ready;
  assign fifo_level = level_q;
  assign state      = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pop      = 1'b0;
    uf_event = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable) state_d = SYNC;
      end
      SYNC: begin
        if (sync_req) cnt_d = '0;
        else if (cnt_q == SYNC_LAST) state_d = PRIME;
        else cnt_d = cnt_q + 8'd1;
      end
      PRIME: begin
        if (sync_req) begin
          state_d = SYNC;
          cnt_d   = '0;
        end else if (level_q >= PRIME_L) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // A resync request holds the buffer so no beat is lost across the burst.
        if (sync_req) begin
          state_d = SYNC;
          cnt_d   = '0;
        end else if (level_q != '0) begin
          pop = 1'b1;
        end else begin
          uf_event = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!enable) begin
      state_d  = IDLE;
      cnt_d    = '0;
      pop      = 1'b0;
      uf_event = 1'b0;
    end
  end

  always_comb begin
    flush   = !enable || (state_q == IDLE);
    ser_d   = pop ? mem[rd_ptr] : '0;
    frame_d = (enable && (state_q == SYNC || state_q == RUN)) ? FRAME_PAT : '0;
    sync_d  = (enable && state_q == SYNC) ? SYNC_PAT : '0;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level_q       <= '0;
      ser_data      <= '0;
      frame_word    <= '0;
      sync_word     <= '0;
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      ser_data   <= ser_d;
      frame_word <= frame_d;
      sync_word  <= sync_d;
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        level_q <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      level_q <= level_q + 1'b1;
        else if (pop && !push) level_q <= level_q - 1'b1;
      end
      // A clear coinciding with a new underflow restarts the count at one.
      if (uf_event) begin
        underflow <= 1'b1;
        if (underflow_clr)                underflow_cnt <= 16'd1;
        else if (underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
      end else if (underflow_clr) begin
        underflow     <= 1'b0;
        underflow_cnt <= '0;
      end
    end
  end

endmodule

// File: doc/dac_lane_framer.md
DAC_LANE_FRAMER -- requirements
Module: dac_lane_framer

Interface
REQ-001 Parameter NUM_CH, default 2: DAC channel count, legal 1..8.
REQ-002 Parameter DATA_WIDTH, default 16: bits per sample.
REQ-003 Parameter RATIO, default 4: samples per channel per clk, legal 4 or 8; phase 0 is transmitted first (serializer D1).
REQ-004 Parameter FIFO_DEPTH, default 8: beat buffer depth, power of 2, 4..64.
REQ-005 Parameter PRIME_LEVEL, default 4: FIFO level needed to start RUN, 1..FIFO_DEPTH.
REQ-006 Parameter SYNC_LEN, default 16: clk cycles spent in SYNC, 1..255.
REQ-007 Parameter FRAME_PAT, default 4'b0011 zero-extended to RATIO bits: frame word, bit p = phase p.
REQ-008 Parameter SYNC_PAT, default 4'b0011 zero-extended to RATIO bits: sync word, bit p = phase p.
REQ-009 Port clk, input, 1: single clock (serializer div_clk rate); the block has one clock.
REQ-010 Port rst, input, 1: reset, synchronous, active-high.
REQ-011 Port enable, input, 1: level; low forces IDLE.
REQ-012 Port sync_req, input, 1: single-cycle request to emit a sync burst.
REQ-013 Port s_valid, input, 1: input beat valid.
REQ-014 Port s_ready, output, 1: input beat accepted when s_valid and s_ready are both high.
REQ-015 Port s_data, input, NUM_CH*RATIO*DATA_WIDTH: beat; sample of channel c, phase p at [(p*NUM_CH+c)*DATA_WIDTH +: DATA_WIDTH].
REQ-016 Port ser_data, output, NUM_CH*RATIO*DATA_WIDTH: registered serializer word, same ordering as s_data.
REQ-017 Port frame_word, output, RATIO: registered frame-lane serializer word.
REQ-018 Port sync_word, output, RATIO: registered sync-lane serializer word.
REQ-019 Port underflow_clr, input, 1: clears underflow status.
REQ-020 Port underflow, output, 1: sticky underflow flag.
REQ-021 Port underflow_cnt, output, 16: saturating underflow count.
REQ-022 Port fifo_level, output, log2(FIFO_DEPTH)+1: current FIFO occupancy.
REQ-023 Port state, output, 2: IDLE=0, SYNC=1, PRIME=2, RUN=3.

Function
REQ-024 s_ready shall be high only when enable is high, rst is low, and fifo_level < FIFO_DEPTH; a push while full shall never occur.
REQ-025 IDLE: ser_data, frame_word, and sync_word shall be all zero, and the FIFO shall be held empty; the next state shall be SYNC when enable is high.
REQ-026 SYNC: the block shall stay exactly SYNC_LEN cycles, then go to PRIME; outputs shall be sync_word=SYNC_PAT, frame_word=FRAME_PAT, ser_data=0; pushes are accepted and there are no pops.
REQ-027 PRIME: the next state shall be RUN in the cycle after fifo_level >= PRIME_LEVEL; outputs shall be as IDLE; there are no pops.
REQ-028 RUN, FIFO non-empty: each cycle shall pop one beat into ser_data, set frame_word=FRAME_PAT, and set sync_word=0.
REQ-029 RUN, FIFO empty: ser_data=0, frame_word=FRAME_PAT, underflow set, underflow_cnt +1 saturating at 0xFFFF; the state shall remain RUN.
REQ-030 Latency: a beat accepted at edge k into an empty FIFO while in RUN shall appear on ser_data after edge k+1; FIFO order shall be strict FIFO.
REQ-031 Push and pop in the same cycle shall leave fifo_level unchanged; pointers shall wrap modulo FIFO_DEPTH.
REQ-032 sync_req high in RUN or PRIME shall cause SYNC next cycle, with the FIFO contents retained; sync_req in SYNC shall restart the SYNC_LEN count; sync_req in IDLE shall be ignored.
REQ-033 enable low in any state shall give IDLE next cycle, flush the FIFO, and zero the outputs at that edge.
REQ-034 underflow_clr shall zero underflow and underflow_cnt; if an underflow occurs in the same cycle, the result shall be underflow=1 and cnt=1.

Reset
REQ-035 rst high shall, at the next edge: set state=IDLE, empty the FIFO, zero ser_data/frame_word/sync_word/underflow/underflow_cnt, and the SYNC counter shall be 0; s_ready shall be low while rst is high.
REQ-036 rst asserted mid-RUN shall discard all buffered beats; no beat accepted before reset shall appear after reset.

Verification
REQ-037 Startup (defaults): rst low, enable high -> 16 cycles sync_word=4'b0011, then PRIME; push 4 ramp beats -> RUN, beats output in order 1 cycle apart, frame_word=4'b0011.
REQ-038 Underflow: in RUN, stop pushing for 3 cycles -> 3 zero words, underflow=1, underflow_cnt=3; pulse underflow_clr -> 0/0.
REQ-039 Backpressure: hold s_valid in PRIME with PRIME_LEVEL=8, FIFO_DEPTH=8 -> s_ready low at level 8, no beat lost or duplicated.
REQ-040 Resync: sync_req mid-RUN with 5 beats buffered -> SYNC_LEN cycles of sync, PRIME, then RUN resumes with the 5 beats intact.
REQ-041 Abort: rst or enable low mid-RUN -> outputs zero next edge, fifo_level=0, state=IDLE.
REQ-042 Config sweep: NUM_CH=8, RATIO=8, FIFO_DEPTH=4 -> lane ordering per REQ-015, FRAME_PAT zero-extended to 8'b00000011.
